hazard_ctrl_param: RTL and testbench
====================================

// Module: hazard_ctrl_param
// PURPOSE
//  Parametrised load-use / control-hazard unit for the 5-stage MIPS pipeline;
//  successor to the fixed 3-enable hazard block. Sits beside ID/EX: compares ID
//  sources against the EX-stage load destination and drives PC, IF/ID and ID/EX
//  enables and flushes. Adds multi-cycle load bubbles, multi-cycle branch flush,
//  $zero exemption, flush-over-stall priority and optional event counters.
// PARAMETERS
//  AW        5   register address width
//  LOAD_LAT  1   bubble cycles per load-use hazard (1..15)
//  FLUSH_LEN 1   flush cycles per taken branch/jump (1..15)
//  CW        16  width of statistics counters (HAZ_STATS_EN only)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-low
//  id_rs        in   AW  ID-stage source register rs
//  id_rt        in   AW  ID-stage source register rt
//  id_uses_rt   in   1   ID instruction reads rt (R-type/store/branch)
//  ex_rt        in   AW  EX-stage destination of instruction in ID/EX
//  ex_memread   in   1   EX-stage instruction is a load
//  pcsrc        in   1   taken branch/jump resolved this cycle
//  pc_en        out  1   PC write enable
//  ifid_en      out  1   IF/ID register write enable
//  ifid_flush   out  1   zero IF/ID contents next edge
//  idex_flush   out  1   insert bubble (zero ctrl) into ID/EX next edge
//  haz_busy     out  1   FSM not in IDLE
//  stall_events out  CW  load-use hazards detected (saturating)
//  flush_events out  CW  branch flushes started (saturating)
// BEHAVIOUR
//  - hit = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - FSM states IDLE, STALL, FLUSH; 4-bit down-counter cnt. Outputs are
//    combinational from state+inputs (same-cycle response); state/cnt registered.
//  - Default outputs: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
//  - IDLE, pcsrc=1: ifid_flush=1, idex_flush=1; if FLUSH_LEN>1 -> FLUSH,
//    cnt=FLUSH_LEN-1, else stay IDLE. pcsrc wins over simultaneous hit.
//  - IDLE, hit, pcsrc=0: pc_en=0, ifid_en=0, idex_flush=1; if LOAD_LAT>1 ->
//    STALL, cnt=LOAD_LAT-1, else stay IDLE.
//  - STALL: same outputs as hit; hit/ex_memread ignored; cnt-- each cycle;
//    cnt==1 -> IDLE. pcsrc=1 in STALL aborts stall: apply IDLE-pcsrc outputs
//    and transitions this cycle.
//  - FLUSH: ifid_flush=1, idex_flush=1, pc_en=ifid_en=1; cnt--; cnt==1 -> IDLE.
//    pcsrc=1 in FLUSH reloads cnt=FLUSH_LEN-1 (newer redirect restarts flush).
//  - haz_busy = (state!=IDLE).
//  - Reset (rst=0 at edge): state=IDLE, cnt=0, counters=0. While rst=0 outputs
//    forced to defaults (enables 1, flushes 0, haz_busy 0) regardless of inputs;
//    reset mid-STALL/FLUSH aborts immediately.
//  - ex_rt==0 never stalls, even with ex_memread=1.
// CONFIGURATION
//  HAZ_STATS_EN defined: stall_events +1 per IDLE->hit cycle accepted (not per
//   bubble cycle); flush_events +1 per cycle pcsrc=1 is accepted; both saturate
//   at 2^CW-1; cleared by reset.
//  HAZ_STATS_EN undefined: counter logic absent; stall_events/flush_events tied
//   to 0 (ports kept for interface stability).
// TESTING
//  1 LOAD_LAT=1: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle pc_en=0,
//    ifid_en=0, idex_flush=1; next cycle defaults, haz_busy=0.
//  2 LOAD_LAT=3: same hit -> 3 consecutive stall cycles, haz_busy=1 for
//    cycles 2-3, then IDLE; stall_events=1 with HAZ_STATS_EN.
//  3 ex_memread=1, ex_rt=0, id_rs=0 -> no stall; ex_rt=9, id_rt=9,
//    id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
//  4 FLUSH_LEN=2: pcsrc=1 together with hit -> ifid_flush=idex_flush=1 for 2
//    cycles, pc_en stays 1, no stall; flush_events=1.
//  5 LOAD_LAT=4: pcsrc=1 in 2nd stall cycle -> stall ends that cycle, flush
//    outputs asserted, pc_en=1.
//  6 rst=0 during FLUSH -> outputs default same cycle, IDLE next edge,
//    counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// ============================================================================
// Module  : hazard_ctrl_param
// Purpose : Parametrised load-use / control-hazard unit for a 5-stage MIPS
//           pipeline. Compares ID-stage sources against the EX-stage load
//           destination and drives PC / IF/ID / ID/EX enables and flushes.
//           Supports multi-cycle load bubbles, multi-cycle branch flush,
//           $zero exemption and flush-over-stall priority.
// Config  : HAZ_STATS_EN - when defined, saturating event counters are built;
//           otherwise stall_events / flush_events are tied to zero.
// Ports   : clk, rst (sync, active-low)
//           id_rs, id_rt, id_uses_rt  - ID-stage operand info
//           ex_rt, ex_memread         - EX-stage load info
//           pcsrc                     - taken branch/jump this cycle
//           pc_en, ifid_en            - write enables (1 = advance)
//           ifid_flush, idex_flush    - zero pipeline register next edge
//           haz_busy                  - FSM not idle
//           stall_events, flush_events - event counters (CW bits)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_param #(
    parameter int AW        = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_LEN = 1,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic [AW-1:0] ex_rt,
    input  logic          ex_memread,
    input  logic          pcsrc,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          haz_busy,
    output logic [CW-1:0] stall_events,
    output logic [CW-1:0] flush_events
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Reload values hold the number of cycles remaining after the first one,
    // which is always served from IDLE.
    localparam logic [3:0] c_LOAD_RELOAD  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] c_FLUSH_RELOAD = 4'(FLUSH_LEN - 1);
    localparam bit         c_LOAD_MULTI   = (LOAD_LAT > 1);
    localparam bit         c_FLUSH_MULTI  = (FLUSH_LEN > 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_hit;
    logic       w_stall_accept;

    // $zero is never a real dependency, so a load to r0 never stalls.
    assign w_hit = ex_memread && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A new load-use hazard is only counted when recognised from IDLE and not
    // overridden by a redirect.
    assign w_stall_accept = rst && (r_state == S_IDLE) && w_hit && !pcsrc;

    // Same-cycle output decode; reset forces the defaults.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE, S_STALL: begin
                    if (pcsrc) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_hit || (r_state == S_STALL)) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                S_FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign haz_busy = rst && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_STALL: begin
                    if (pcsrc) begin
                        // Redirect wins over a pending or in-progress stall.
                        if (c_FLUSH_MULTI) begin
                            r_state <= S_FLUSH;
                            r_cnt   <= c_FLUSH_RELOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_state == S_STALL) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_hit && c_LOAD_MULTI) begin
                        r_state <= S_STALL;
                        r_cnt   <= c_LOAD_RELOAD;
                    end
                end
                S_FLUSH: begin
                    if (pcsrc) begin
                        // A younger redirect restarts the flush window.
                        r_cnt <= c_FLUSH_RELOAD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_stall_events;
    logic [CW-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_events <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_accept && (r_stall_events != c_CNT_MAX)) begin
                r_stall_events <= r_stall_events + c_CNT_ONE;
            end
            // Every accepted redirect counts, whatever state it arrives in.
            if (pcsrc && (r_flush_events != c_CNT_MAX)) begin
                r_flush_events <= r_flush_events + c_CNT_ONE;
            end
        end
    end

    assign stall_events = r_stall_events;
    assign flush_events = r_flush_events;
`else
    logic w_unused;
    assign w_unused     = w_stall_accept;
    assign stall_events = '0;
    assign flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_param.sv
// ============================================================================
// Module  : tb_hazard_ctrl_param
// Purpose : Directed self-checking bench for hazard_ctrl_param. Three
//           instances with different LOAD_LAT / FLUSH_LEN share one stimulus
//           stream; each output group is compared to hand-computed values.
//           Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush,
//           haz_busy}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_param;

    localparam int AW = 5;
    localparam int CW = 16;

    // Expected output patterns
    localparam logic [4:0] c_DEF  = 5'b11000; // defaults, idle
    localparam logic [4:0] c_STI  = 5'b00010; // stall from IDLE
    localparam logic [4:0] c_STB  = 5'b00011; // stall while busy
    localparam logic [4:0] c_FLI  = 5'b11110; // flush from IDLE
    localparam logic [4:0] c_FLB  = 5'b11111; // flush while busy

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_memread, pcsrc;

    logic pc_en_a, ifid_en_a, ifid_flush_a, idex_flush_a, haz_busy_a;
    logic pc_en_b, ifid_en_b, ifid_flush_b, idex_flush_b, haz_busy_b;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, haz_busy_c;
    logic [CW-1:0] se_a, fe_a, se_b, fe_b, se_c, fe_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_param #(.AW(AW), .LOAD_LAT(1), .FLUSH_LEN(1), .CW(CW)) u_dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .pcsrc(pcsrc), .pc_en(pc_en_a), .ifid_en(ifid_en_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
        .haz_busy(haz_busy_a), .stall_events(se_a), .flush_events(fe_a)
    );

    hazard_ctrl_param #(.AW(AW), .LOAD_LAT(3), .FLUSH_LEN(2), .CW(CW)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .pcsrc(pcsrc), .pc_en(pc_en_b), .ifid_en(ifid_en_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
        .haz_busy(haz_busy_b), .stall_events(se_b), .flush_events(fe_b)
    );

    hazard_ctrl_param #(.AW(AW), .LOAD_LAT(4), .FLUSH_LEN(2), .CW(CW)) u_dut_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .pcsrc(pcsrc), .pc_en(pc_en_c), .ifid_en(ifid_en_c),
        .ifid_flush(ifid_flush_c), .idex_flush(idex_flush_c),
        .haz_busy(haz_busy_c), .stall_events(se_c), .flush_events(fe_c)
    );

    logic [4:0] w_out_a, w_out_b, w_out_c;
    assign w_out_a = {pc_en_a, ifid_en_a, ifid_flush_a, idex_flush_a, haz_busy_a};
    assign w_out_b = {pc_en_b, ifid_en_b, ifid_flush_b, idex_flush_b, haz_busy_b};
    assign w_out_c = {pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, haz_busy_c};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counter expectation: zero when statistics are not built.
    function automatic logic [31:0] ev(input int v);
`ifdef HAZ_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [AW-1:0] ert,
                          input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic urt, input logic pc);
        ex_memread = mr;
        ex_rt      = ert;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = urt;
        pcsrc      = pc;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] ea,
                           input logic [4:0] eb, input logic [4:0] ec);
        check({tag, "_a"}, 32'(w_out_a), 32'(ea));
        check({tag, "_b"}, 32'(w_out_b), 32'(eb));
        check({tag, "_c"}, 32'(w_out_c), 32'(ec));
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        check({tag, "_se_a"}, 32'(se_a), ev(s));
        check({tag, "_se_b"}, 32'(se_b), ev(s));
        check({tag, "_se_c"}, 32'(se_c), ev(s));
        check({tag, "_fe_a"}, 32'(fe_a), ev(f));
        check({tag, "_fe_b"}, 32'(fe_b), ev(f));
        check({tag, "_fe_c"}, 32'(fe_c), ev(f));
    endtask

    initial begin
        // Reset with hazard and redirect driven: outputs must stay default.
        rst = 1'b0;
        set_in(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1);
        chk_out("rst_force", c_DEF, c_DEF, c_DEF);
        tick();
        tick();
        chk_out("rst_hold", c_DEF, c_DEF, c_DEF);
        chk_cnt("rst_cnt", 0, 0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("idle", c_DEF, c_DEF, c_DEF);
        tick();

        // Load-use on rs: 1 / 3 / 4 bubble cycles.
        set_in(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0);
        chk_out("lu_c1", c_STI, c_STI, c_STI);
        tick();
        set_in(1'b0, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0);
        chk_out("lu_c2", c_DEF, c_STB, c_STB);
        tick();
        chk_out("lu_c3", c_DEF, c_STB, c_STB);
        tick();
        chk_out("lu_c4", c_DEF, c_DEF, c_STB);
        tick();
        chk_out("lu_c5", c_DEF, c_DEF, c_DEF);
        chk_cnt("lu_cnt", 1, 0);

        // $zero exemption and id_uses_rt gating.
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk_out("zero", c_DEF, c_DEF, c_DEF);
        tick();
        set_in(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0);
        chk_out("rt_unused", c_DEF, c_DEF, c_DEF);
        tick();
        set_in(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0);
        chk_out("rt_used", c_STI, c_STI, c_STI);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk_out("rt_drain", c_DEF, c_DEF, c_DEF);
        chk_cnt("rt_cnt", 2, 0);

        // Redirect together with a hazard: flush wins, no stall.
        set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
        chk_out("br_c1", c_FLI, c_FLI, c_FLI);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_out("br_c2", c_DEF, c_FLB, c_FLB);
        tick();
        chk_out("br_c3", c_DEF, c_DEF, c_DEF);
        chk_cnt("br_cnt", 2, 1);

        // Redirect in the second stall cycle aborts the stall.
        set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
        chk_out("ab_c1", c_STI, c_STI, c_STI);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk_out("ab_c2", c_FLI, c_FLB, c_FLB);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_out("ab_c3", c_DEF, c_FLB, c_FLB);
        tick();
        chk_out("ab_c4", c_DEF, c_DEF, c_DEF);
        chk_cnt("ab_cnt", 3, 2);

        // Redirect during FLUSH restarts the window.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk_out("rl_c2", c_FLI, c_FLB, c_FLB);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_out("rl_c3", c_DEF, c_FLB, c_FLB);
        tick();
        chk_out("rl_c4", c_DEF, c_DEF, c_DEF);
        chk_cnt("rl_cnt", 3, 4);

        // Reset asserted mid-FLUSH.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk_out("rf_pre", c_FLI, c_FLB, c_FLB);
        rst = 1'b0;
        #1;
        chk_out("rf_force", c_DEF, c_DEF, c_DEF);
        tick();
        chk_cnt("rf_cnt", 0, 0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("rf_idle", c_DEF, c_DEF, c_DEF);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
